// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter
//
// Multi-digit BCD up/down counter with a time-multiplexed display scanner.
// It feeds a single shared Seven_Seg_Display: each scan slot presents one
// digit on BCD with its Blanking qualifier, plus a one-hot digit enable for
// the digit drivers.
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   defined     - leading zero digits (above digit 0) are blanked
//   not defined - every digit is displayed, leading zeros included
//
// Parameters
//   DIGITS    number of BCD digits (2..8)
//   SCAN_DIV  clock cycles each digit stays selected (>= 2)
//
// Ports
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   clear      synchronous clear of the count (highest priority)
//   load       load load_val into the count; non-decimal digits load as 0
//   load_val   packed BCD load value, digit 0 in bits [3:0]
//   en         count enable, one step per cycle
//   up         direction: 1 = increment, 0 = decrement
//   count      current packed BCD count (registered)
//   carry      one-cycle pulse when the count wraps in either direction
//   BCD        digit value for the display decoder (registered)
//   Blanking   blank request for the display decoder (registered)
//   digit_sel  one-hot active-high digit enable (registered)

module bcd_scan_counter #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   count,
    output logic                  carry,
    output logic [3:0]            BCD,
    output logic                  Blanking,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // ------------------------------------------------------------------
    // Count path
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] count_next;
    logic                carry_next;
    logic                ripple;
    logic [3:0]          dig;

    // ripple starts set on a count step and survives a digit only while
    // that digit wraps (9->0 up, 0->9 down); if it survives the top digit
    // the whole count wrapped and carry is raised.
    always_comb begin
        count_next = count;
        carry_next = 1'b0;
        ripple     = 1'b0;
        dig        = 4'd0;
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            for (int i = 0; i < DIGITS; i++) begin
                dig = load_val[4*i +: 4];
                count_next[4*i +: 4] = (dig > 4'd9) ? 4'd0 : dig;
            end
        end else if (en) begin
            ripple = 1'b1;
            for (int i = 0; i < DIGITS; i++) begin
                dig = count[4*i +: 4];
                if (ripple) begin
                    if (up) begin
                        if (dig >= 4'd9) begin
                            count_next[4*i +: 4] = 4'd0;
                        end else begin
                            count_next[4*i +: 4] = dig + 4'd1;
                            ripple = 1'b0;
                        end
                    end else begin
                        if (dig == 4'd0) begin
                            count_next[4*i +: 4] = 4'd9;
                        end else begin
                            count_next[4*i +: 4] = dig - 4'd1;
                            ripple = 1'b0;
                        end
                    end
                end
            end
            carry_next = ripple;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            carry <= 1'b0;
        end else begin
            count <= count_next;
            carry <= carry_next;
        end
    end

    // ------------------------------------------------------------------
    // Scan path: free-running, untouched by clear/load/en
    // ------------------------------------------------------------------
    logic [PRE_W-1:0] pre;
    logic [IDX_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PRE_LAST) begin
            pre <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Display output register
    // ------------------------------------------------------------------
    logic [3:0]        digit_val [DIGITS];
    logic [DIGITS-1:0] sel_next;
    logic              blank_next;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign digit_val[g] = count[4*g +: 4];
    end

    always_comb begin
        sel_next      = '0;
        sel_next[idx] = 1'b1;
    end

`ifdef LEADING_ZERO_BLANK_EN
    // zero_from[i]: digit i and every digit above it are zero
    logic [DIGITS-1:0] zero_from;

    always_comb begin
        zero_from             = '0;
        zero_from[DIGITS-1]   = (digit_val[DIGITS-1] == 4'd0);
        for (int i = DIGITS - 2; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (digit_val[i] == 4'd0);
        end
    end

    // digit 0 always shows, so a zero count still reads "0"
    assign blank_next = (idx != '0) && zero_from[idx];
`else
    assign blank_next = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_sel <= '0;
            BCD       <= 4'd0;
            Blanking  <= 1'b1;
        end else begin
            digit_sel <= sel_next;
            BCD       <= digit_val[idx];
            Blanking  <= blank_next;
        end
    end

endmodule

// File: tb/tb_bcd_scan_counter.sv
module tb_bcd_scan_counter;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0;
    logic        en = 1'b0;
    logic        up = 1'b0;
    logic [15:0] count;
    logic        carry;
    logic [3:0]  BCD;
    logic        Blanking;
    logic [3:0]  digit_sel;

    bcd_scan_counter #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .load(load),
        .load_val(load_val), .en(en), .up(up), .count(count),
        .carry(carry), .BCD(BCD), .Blanking(Blanking), .digit_sel(digit_sel)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: count as a plain decimal integer, scan position as
    // the number of non-reset edges since reset
    int         m_count = 0;
    bit         m_carry = 0;
    int         m_n     = 0;
    logic [3:0] e_sel   = 4'h0;
    logic [3:0] e_bcd   = 4'h0;
    bit         e_blank = 1'b1;

    function automatic int pow10(int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic int sanitize(logic [15:0] v);
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            int nib = int'((v >> (4*i)) & 16'hF);
            if (nib > 9) nib = 0;
            r = r + nib * pow10(i);
        end
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(int v);
        logic [15:0] r = 16'h0;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(bit r, bit c, bit l, logic [15:0] lv, bit e, bit u);
        int ip;
        rst_n = r; clear = c; load = l; load_val = lv; en = e; up = u;
        @(posedge clk);
        if (!r) begin
            m_count = 0; m_carry = 0; m_n = 0;
            e_sel = 4'h0; e_bcd = 4'h0; e_blank = 1'b1;
        end else begin
            ip = (m_n / SCAN_DIV) % DIGITS;
            e_sel = 4'(1 << ip);
            e_bcd = 4'((m_count / pow10(ip)) % 10);
`ifdef LEADING_ZERO_BLANK_EN
            e_blank = (ip > 0) && (m_count < pow10(ip));
`else
            e_blank = 1'b0;
`endif
            m_n++;
            m_carry = 0;
            if (c) m_count = 0;
            else if (l) m_count = sanitize(lv);
            else if (e) begin
                if (u) begin
                    if (m_count == 9999) begin m_count = 0; m_carry = 1; end
                    else m_count = m_count + 1;
                end else begin
                    if (m_count == 0) begin m_count = 9999; m_carry = 1; end
                    else m_count = m_count - 1;
                end
            end
        end
        #1;
        check("count", count, to_bcd(m_count));
        check("carry", carry, m_carry);
        check("digit_sel", digit_sel, e_sel);
        check("BCD", BCD, e_bcd);
        check("Blanking", Blanking, e_blank);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 16'h0, 0, 0);
    endtask

    initial begin
        // reset for 3 cycles, then free-running scan
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 0, 0);
        check("rst_sel_zero", digit_sel, 4'h0);
        idle(1);
        check("first_sel", digit_sel, 4'h1);
        idle(35);

        // up wrap
        step(1, 0, 1, 16'h9998, 0, 0);
        step(1, 0, 0, 16'h0, 1, 1);
        check("up_9999", count, 16'h9999);
        step(1, 0, 0, 16'h0, 1, 1);
        check("wrap_carry", carry, 1'b1);
        idle(1);
        check("carry_one_cycle", carry, 1'b0);

        // down borrow and down wrap
        step(1, 0, 1, 16'h1000, 0, 0);
        step(1, 0, 0, 16'h0, 1, 0);
        check("borrow_0999", count, 16'h0999);
        step(1, 0, 1, 16'h0000, 0, 0);
        step(1, 0, 0, 16'h0, 1, 0);
        check("down_wrap", count, 16'h9999);
        idle(1);

        // priority and load sanitising
        step(1, 1, 1, 16'h1234, 1, 1);
        step(1, 0, 1, 16'h3A7F, 1, 1);
        check("load_sanitize", count, 16'h3070);
        step(1, 0, 0, 16'h0, 1, 0);
        step(1, 0, 1, 16'h5555, 1, 0);

        // blanking: hold 0042 across full refresh periods
        step(1, 0, 1, 16'h0042, 0, 0);
        idle(2 * DIGITS * SCAN_DIV);
        step(1, 0, 1, 16'h0000, 0, 0);
        idle(DIGITS * SCAN_DIV + 1);
        step(1, 0, 1, 16'h0700, 0, 0);
        idle(DIGITS * SCAN_DIV + 1);

        // randomized controls
        for (int i = 0; i < 300; i++) begin
            bit c = ($urandom_range(0, 19) == 0);
            bit l = ($urandom_range(0, 9) == 0);
            bit e = ($urandom_range(0, 2) != 0);
            bit u = $urandom_range(0, 1) != 0;
            logic [15:0] lv;
            if ($urandom_range(0, 1) != 0) lv = 16'($urandom);
            else lv = ($urandom_range(0, 1) != 0) ? 16'h9997 : 16'h0002;
            step(1, c, l, lv, e, u);
        end

        // reset mid-operation while scanning digit 2
        for (int i = 0; i < 2 * DIGITS * SCAN_DIV; i++) begin
            if ((m_n / SCAN_DIV) % DIGITS == 2) break;
            step(1, 0, 0, 16'h0, 1, 1);
        end
        step(1, 0, 0, 16'h0, 1, 1);
        step(0, 0, 0, 16'h0, 1, 1);
        check("midrst_count", count, 16'h0);
        check("midrst_sel", digit_sel, 4'h0);
        step(1, 0, 0, 16'h0, 1, 1);
        check("restart_sel", digit_sel, 4'h1);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 16'h0, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
